// File: rtl/axis_state_tx.sv
// Streams a captured 1600-bit Keccak state out as DATA_WIDTH-bit AXI-Stream beats.
// Each beat carries its word index on TDEST. TLAST and TID mark the final beat of a frame.
module axis_state_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WORDS  = 1600 / DATA_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [0:4][0:4][63:0] D_in,
  input  logic                  start,
  input  logic                  TREADY,
  output logic [DATA_WIDTH-1:0] TDATA,
  output logic [7:0]            TDEST,
  output logic                  TVALID,
  output logic                  TLAST,
  output logic                  TID,
  output logic                  busy,
  output logic                  done
);

  localparam int         STATE_BITS  = 1600;
  localparam int         TOTAL_WORDS = STATE_BITS / DATA_WIDTH;
  localparam int         IDX_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam logic [7:0] LAST_IDX    = 8'(OUT_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                                 state, state_nxt;
  logic [7:0]                             cnt, cnt_nxt, cnt_inc;
  logic [IDX_W-1:0]                       word_sel;
  logic [DATA_WIDTH-1:0]                  tdata_q, tdata_nxt;
  logic                                   tlast_q, tlast_nxt;
  logic                                   done_q, done_nxt;
  logic                                   load, hs;
  logic [STATE_BITS-1:0]                  flat;
  logic [TOTAL_WORDS-1:0][DATA_WIDTH-1:0] flat_words, hold_words;

  // Lane [x][y] sits at flat bits 64*(5*y+x) +: 64.
  always_comb begin
    flat = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        flat[64*(5*y+x) +: 64] = D_in[x][y];
      end
    end
  end

  assign flat_words = flat;

  // A handshake can only happen in SEND, because TVALID is the state bit.
  assign hs       = TVALID & TREADY;
  assign cnt_inc  = cnt + 8'd1;
  assign word_sel = IDX_W'(cnt_inc);

  always_comb begin
    // NOTE: every signal is given a default first, so a path that misses an assignment cannot infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    tdata_nxt = tdata_q;
    tlast_nxt = tlast_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
          cnt_nxt   = 8'd0;
          tdata_nxt = flat_words[0];
          tlast_nxt = (LAST_IDX == 8'd0);
        end
      end
      SEND: begin
        if (hs) begin
          if (cnt == LAST_IDX) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            tdata_nxt = '0;
            tlast_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt   = cnt_inc;
            tdata_nxt = hold_words[word_sel];
            tlast_nxt = (cnt_inc == LAST_IDX);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tdata_q <= tdata_nxt;
      tlast_q <= tlast_nxt;
      done_q  <= done_nxt;
    end
  end

  // NOTE: the holding register is deliberately left out of reset. A frame always loads it before any word is read.
  always_ff @(posedge ACLK) begin
    if (load) begin
      hold_words <= flat_words;
    end
  end

  assign TVALID = (state == SEND);
  assign busy   = (state == SEND);
  assign TDEST  = cnt;
  assign TDATA  = tdata_q;
  assign TLAST  = tlast_q;
  assign TID    = tlast_q;
  assign done   = done_q;

endmodule
